// File: rtl/vx_mem_responder.sv
// Backing-memory responder for the Vortex mem_req/mem_rsp interface.
// Writes update storage directly. Reads are queued in order and answered after RSP_LATENCY cycles.
module vx_mem_responder #(
    parameter int DATA_W      = 512,
    parameter int ADDR_W      = 26,
    parameter int TAG_W       = 8,
    parameter int MEM_WORDS   = 64,
    parameter int RSP_LATENCY = 4,
    parameter int Q_DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_req_valid,
    input  logic                  mem_req_rw,
    input  logic [DATA_W/8-1:0]   mem_req_byteen,
    input  logic [ADDR_W-1:0]     mem_req_addr,
    input  logic [DATA_W-1:0]     mem_req_data,
    input  logic [TAG_W-1:0]      mem_req_tag,
    output logic                  mem_req_ready,
    output logic                  mem_rsp_valid,
    output logic [DATA_W-1:0]     mem_rsp_data,
    output logic [TAG_W-1:0]      mem_rsp_tag,
    input  logic                  mem_rsp_ready,
    output logic                  busy,
    output logic                  addr_oob
);

    localparam int BYTES_W = DATA_W / 8;
    localparam int IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int PTR_W   = $clog2(Q_DEPTH);
    localparam int CNT_W   = (RSP_LATENCY > 1) ? $clog2(RSP_LATENCY) : 1;

    localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(RSP_LATENCY - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_WORDS);

    logic [DATA_W-1:0] r_mem    [MEM_WORDS];
    logic [DATA_W-1:0] r_q_data [Q_DEPTH];
    logic [TAG_W-1:0]  r_q_tag  [Q_DEPTH];
    logic [CNT_W-1:0]  r_q_cnt  [Q_DEPTH];
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic              r_addr_oob;

    logic              w_full;
    logic              w_empty;
    logic              w_in_range;
    logic              w_accept;
    logic              w_push;
    logic              w_wr_en;
    logic              w_head_rdy;
    logic              w_pop;
    logic [PTR_W-1:0]  w_wr_idx;
    logic [PTR_W-1:0]  w_rd_idx;
    logic [IDX_W-1:0]  w_mem_idx;
    logic [DATA_W-1:0] w_rd_data;

    assign w_wr_idx   = r_wr_ptr[PTR_W-1:0];
    assign w_rd_idx   = r_rd_ptr[PTR_W-1:0];
    assign w_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) && (w_wr_idx == w_rd_idx);
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_in_range = (mem_req_addr < MEM_LIMIT);
    assign w_mem_idx  = mem_req_addr[IDX_W-1:0];

    // Ready depends only on fullness, so a pop never lets a new request in the same cycle.
    assign w_accept   = mem_req_valid && !w_full;
    assign w_push     = w_accept && !mem_req_rw;
    assign w_wr_en    = w_accept && mem_req_rw && w_in_range;
    assign w_rd_data  = w_in_range ? r_mem[w_mem_idx] : '0;

    assign w_head_rdy = !w_empty && (r_q_cnt[w_rd_idx] == '0);
    assign w_pop      = w_head_rdy && mem_rsp_ready;

    assign mem_req_ready = !w_full;
    assign mem_rsp_valid = w_head_rdy;
    assign mem_rsp_data  = w_head_rdy ? r_q_data[w_rd_idx] : '0;
    assign mem_rsp_tag   = w_head_rdy ? r_q_tag[w_rd_idx]  : '0;
    assign busy          = !w_empty;
    assign addr_oob      = r_addr_oob;

    // Queue control: pointers, per-entry countdowns and the sticky out-of-range flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_addr_oob <= 1'b0;
            for (int i = 0; i < Q_DEPTH; i++) begin
                r_q_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                if (r_q_cnt[i] != '0) begin
                    r_q_cnt[i] <= r_q_cnt[i] - CNT_ONE;
                end
            end
            if (w_push) begin
                r_q_cnt[w_wr_idx] <= CNT_INIT;
                r_wr_ptr          <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_accept && !w_in_range) begin
                r_addr_oob <= 1'b1;
            end
        end
    end

    // Read payload is captured from storage as it stood before this edge.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[w_wr_idx] <= w_rd_data;
            r_q_tag[w_wr_idx]  <= mem_req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < BYTES_W; b++) begin
                if (mem_req_byteen[b]) begin
                    r_mem[w_mem_idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_vx_mem_responder.sv
// Self-checking bench for vx_mem_responder against a queue-based reference model.
module tb_vx_mem_responder;

    localparam int DATA_W      = 512;
    localparam int ADDR_W      = 26;
    localparam int TAG_W       = 8;
    localparam int MEM_WORDS   = 64;
    localparam int RSP_LATENCY = 4;
    localparam int Q_DEPTH     = 4;
    localparam int NB          = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              mem_req_valid = 1'b0;
    logic              mem_req_rw = 1'b0;
    logic [NB-1:0]     mem_req_byteen = '0;
    logic [ADDR_W-1:0] mem_req_addr = '0;
    logic [DATA_W-1:0] mem_req_data = '0;
    logic [TAG_W-1:0]  mem_req_tag = '0;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;
    logic [TAG_W-1:0]  mem_rsp_tag;
    logic              mem_rsp_ready = 1'b1;
    logic              busy;
    logic              addr_oob;

    vx_mem_responder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W),
        .MEM_WORDS(MEM_WORDS), .RSP_LATENCY(RSP_LATENCY), .Q_DEPTH(Q_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
        .busy(busy), .addr_oob(addr_oob)
    );

    always #5 clk = ~clk;

    // Reference model: pending reads carry their data, tag and the edge count at which they become due.
    typedef struct {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        int                due;
    } rd_t;

    rd_t               m_q[$];
    logic [DATA_W-1:0] m_mem [MEM_WORDS];
    bit                m_oob = 1'b0;
    int                edges = 0;
    int                n_checks = 0;
    int                n_pass = 0;

    function automatic bit m_valid();
        return (m_q.size() > 0) && (edges >= m_q[0].due);
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Advance one clock, applying to the model what the spec says happens on that edge.
    task automatic tick();
        bit  acc;
        bit  pop;
        int  a;
        rd_t e;
        acc = !reset && mem_req_valid && (m_q.size() < Q_DEPTH);
        pop = !reset && m_valid() && mem_rsp_ready;
        a   = int'(mem_req_addr);
        e.data = '0;
        e.tag  = mem_req_tag;
        e.due  = edges + RSP_LATENCY;
        if (acc) begin
            if (a >= MEM_WORDS) m_oob = 1'b1;
            if (mem_req_rw) begin
                if (a < MEM_WORDS)
                    for (int b = 0; b < NB; b++)
                        if (mem_req_byteen[b]) m_mem[a][b*8 +: 8] = mem_req_data[b*8 +: 8];
            end else if (a < MEM_WORDS) begin
                e.data = m_mem[a];
            end
        end
        if (pop) void'(m_q.pop_front());
        if (acc && !mem_req_rw) m_q.push_back(e);
        @(posedge clk);
        edges++;
        @(negedge clk);
        if (acc) mem_req_valid = 1'b0;
    endtask

    task automatic issue(input bit rw, input int addr, input logic [TAG_W-1:0] tag,
                         input logic [DATA_W-1:0] data, input logic [NB-1:0] be);
        mem_req_rw     = rw;
        mem_req_addr   = ADDR_W'(addr);
        mem_req_tag    = tag;
        mem_req_data   = data;
        mem_req_byteen = be;
        mem_req_valid  = 1'b1;
        for (int t = 0; t < 50 && mem_req_valid; t++) tick();
        if (mem_req_valid) begin
            n_checks++;
            $display("FAIL issue_timeout: addr %0d still waiting after 50 cycles, required acceptance", addr);
            mem_req_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int limit, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < limit; t++) begin
            if (mem_rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (mem_rsp_valid === 1'b1) ok = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m_q.delete();
        m_oob = 1'b0;
        repeat (13) tick();
        n_checks++;
        if ({mem_req_ready, mem_rsp_valid, busy, addr_oob} !== 4'b1000)
            $display("FAIL reset_ctrl: got rdy/vld/busy/oob=%b required 1000",
                     {mem_req_ready, mem_rsp_valid, busy, addr_oob});
        else n_pass++;
        n_checks++;
        if (mem_rsp_data !== '0 || mem_rsp_tag !== '0)
            $display("FAIL reset_rsp: got tag %h data %h required 0", mem_rsp_tag, mem_rsp_data);
        else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++;
        if (mem_req_ready !== 1'b1 || mem_rsp_valid !== 1'b0)
            $display("FAIL reset_release: got rdy=%b vld=%b required 1/0", mem_req_ready, mem_rsp_valid);
        else n_pass++;
    endtask

    task automatic test_fill();
        mem_rsp_ready = 1'b1;
        for (int a = 0; a < MEM_WORDS; a++) issue(1'b1, a, '0, rand_data(), '1);
        n_checks++;
        if (busy !== 1'b0 || mem_rsp_valid !== 1'b0)
            $display("FAIL fill_no_rsp: got busy=%b vld=%b required 0/0", busy, mem_rsp_valid);
        else n_pass++;
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] pat;
        int acc_edge;
        int lat;
        bit ok;
        pat = {16{32'hA5A5_0003}};
        mem_rsp_ready = 1'b1;
        issue(1'b1, 3, '0, pat, '1);
        issue(1'b0, 3, 8'h11, '0, '0);
        acc_edge = edges;
        wait_rsp(20, ok);
        lat = edges - acc_edge + 1;
        n_checks++;
        if (!ok || lat != RSP_LATENCY)
            $display("FAIL wr_rd_latency: got %0d (seen=%0d) required %0d", lat, ok, RSP_LATENCY);
        else n_pass++;
        n_checks++;
        if (mem_rsp_data !== pat) $display("FAIL wr_rd_data: got %h required %h", mem_rsp_data, pat);
        else n_pass++;
        n_checks++;
        if (mem_rsp_tag !== 8'h11 || busy !== 1'b1)
            $display("FAIL wr_rd_tag: got tag %h busy %b required 11/1", mem_rsp_tag, busy);
        else n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b0 || mem_rsp_valid !== 1'b0)
            $display("FAIL wr_rd_busy_drop: got busy=%b vld=%b required 0/0", busy, mem_rsp_valid);
        else n_pass++;
    endtask

    task automatic test_partial_write();
        logic [DATA_W-1:0] expd;
        bit ok;
        expd = '0;
        expd[31:0] = 32'hFFFF_FFFF;
        mem_rsp_ready = 1'b1;
        issue(1'b1, 5, '0, '0, '1);
        issue(1'b1, 5, '0, '1, NB'(64'h0F));
        issue(1'b0, 5, 8'h22, '0, '0);
        wait_rsp(20, ok);
        n_checks++;
        if (!ok || mem_rsp_data !== expd || mem_rsp_tag !== 8'h22)
            $display("FAIL partial_write: got tag %h data %h required tag 22 data %h", mem_rsp_tag, mem_rsp_data, expd);
        else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        mem_rsp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) issue(1'b0, 10 + i, TAG_W'(i), '0, '0);
        n_checks++;
        if (mem_req_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL bp_full: got rdy=%b busy=%b required 0/1", mem_req_ready, busy);
        else n_pass++;
        mem_req_rw = 1'b0; mem_req_addr = ADDR_W'(20); mem_req_tag = 8'd5; mem_req_valid = 1'b1;
        repeat (6) tick();
        n_checks++;
        if (mem_req_ready !== 1'b0 || mem_rsp_valid !== 1'b1 || mem_rsp_tag !== 8'd1)
            $display("FAIL bp_hold: got rdy=%b vld=%b tag=%h required 0/1/01", mem_req_ready, mem_rsp_valid, mem_rsp_tag);
        else n_pass++;
        mem_rsp_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (mem_rsp_valid !== 1'b1 || mem_rsp_tag !== TAG_W'(k) || mem_rsp_data !== m_mem[10 + k])
                $display("FAIL bp_drain_%0d: got vld=%b tag=%h required 1/%h", k, mem_rsp_valid, mem_rsp_tag, TAG_W'(k));
            else n_pass++;
            tick();
        end
        wait_rsp(20, ok);
        n_checks++;
        if (!ok || mem_rsp_tag !== 8'd5 || mem_rsp_data !== m_mem[20])
            $display("FAIL bp_fifth: got vld=%b tag=%h required 1/05", ok, mem_rsp_tag);
        else n_pass++;
        tick();
    endtask

    task automatic test_oob();
        bit ok;
        mem_rsp_ready = 1'b1;
        issue(1'b0, MEM_WORDS, 8'h7E, '0, '0);
        n_checks++;
        if (addr_oob !== 1'b1) $display("FAIL oob_flag: got %b required 1", addr_oob);
        else n_pass++;
        wait_rsp(20, ok);
        n_checks++;
        if (!ok || mem_rsp_data !== '0 || mem_rsp_tag !== 8'h7E)
            $display("FAIL oob_read: got tag %h data %h required tag 7e data 0", mem_rsp_tag, mem_rsp_data);
        else n_pass++;
        tick();
        issue(1'b1, MEM_WORDS + 6, '0, rand_data(), '1);
        issue(1'b0, MEM_WORDS + 6, 8'h7F, '0, '0);
        wait_rsp(20, ok);
        n_checks++;
        if (!ok || mem_rsp_data !== '0 || addr_oob !== 1'b1)
            $display("FAIL oob_write_dropped: got data %h oob %b required 0/1", mem_rsp_data, addr_oob);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        bit seen;
        int acc_edge;
        int lat;
        int addrs[4];
        n_checks++;
        if (addr_oob !== 1'b1) $display("FAIL oob_sticky: got %b required 1", addr_oob);
        else n_pass++;
        mem_rsp_ready = 1'b1;
        issue(1'b0, 1, 8'h31, '0, '0);
        issue(1'b0, 2, 8'h32, '0, '0);
        tick();
        reset = 1'b1;
        m_q.delete();
        m_oob = 1'b0;
        #1;
        n_checks++;
        if (mem_rsp_valid !== 1'b0 || busy !== 1'b0 || addr_oob !== 1'b0)
            $display("FAIL midreset_clear: got vld=%b busy=%b oob=%b required 0/0/0", mem_rsp_valid, busy, addr_oob);
        else n_pass++;
        seen = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (mem_rsp_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        n_checks++;
        if (seen) $display("FAIL midreset_no_rsp: got a response after reset, required none");
        else n_pass++;
        issue(1'b0, 3, 8'h40, '0, '0);
        acc_edge = edges;
        wait_rsp(20, ok);
        lat = edges - acc_edge + 1;
        n_checks++;
        if (!ok || lat != RSP_LATENCY || mem_rsp_tag !== 8'h40 || mem_rsp_data !== m_mem[3])
            $display("FAIL postreset_read: got lat %0d tag %h required lat %0d tag 40", lat, mem_rsp_tag, RSP_LATENCY);
        else n_pass++;
        tick();
        for (int r = 0; r < 10; r++) begin
            mem_rsp_ready = 1'b0;
            for (int k = 0; k < 4; k++) begin
                addrs[k] = $urandom_range(0, MEM_WORDS - 1);
                issue(1'b0, addrs[k], TAG_W'(r * 4 + k), '0, '0);
            end
            n_checks++;
            if (mem_req_ready !== 1'b0) $display("FAIL wrap_full_%0d: got rdy %b required 0", r, mem_req_ready);
            else n_pass++;
            mem_rsp_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                wait_rsp(20, ok);
                n_checks++;
                if (!ok || mem_rsp_tag !== TAG_W'(r * 4 + k) || mem_rsp_data !== m_mem[addrs[k]])
                    $display("FAIL wrap_rsp_%0d_%0d: got tag %h required %h", r, k, mem_rsp_tag, TAG_W'(r * 4 + k));
                else n_pass++;
                tick();
            end
        end
    endtask

    task automatic test_random();
        bit ev;
        for (int c = 0; c < 400; c++) begin
            ev = m_valid();
            n_checks++;
            if (mem_req_ready !== (m_q.size() < Q_DEPTH) || busy !== (m_q.size() > 0))
                $display("FAIL rnd_ctrl_%0d: got rdy=%b busy=%b required %b/%b", c, mem_req_ready, busy,
                         (m_q.size() < Q_DEPTH), (m_q.size() > 0));
            else n_pass++;
            n_checks++;
            if (mem_rsp_valid !== ev || addr_oob !== m_oob)
                $display("FAIL rnd_vld_%0d: got vld=%b oob=%b required %b/%b", c, mem_rsp_valid, addr_oob, ev, m_oob);
            else n_pass++;
            if (ev) begin
                n_checks++;
                if (mem_rsp_tag !== m_q[0].tag || mem_rsp_data !== m_q[0].data)
                    $display("FAIL rnd_rsp_%0d: got tag %h required %h", c, mem_rsp_tag, m_q[0].tag);
                else n_pass++;
            end
            mem_req_valid  = ($urandom_range(0, 9) < 6);
            mem_req_rw     = ($urandom_range(0, 9) < 4);
            mem_req_addr   = ADDR_W'($urandom_range(0, MEM_WORDS + 5));
            mem_req_tag    = TAG_W'($urandom);
            mem_req_data   = rand_data();
            mem_req_byteen = {$urandom, $urandom};
            mem_rsp_ready  = ($urandom_range(0, 9) < 7);
            tick();
        end
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b1;
        repeat (20) tick();
        n_checks++;
        if (busy !== 1'b0 || m_q.size() != 0)
            $display("FAIL rnd_drain: got busy=%b model depth %0d required 0/0", busy, m_q.size());
        else n_pass++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_fill();
        test_write_read();
        test_partial_write();
        test_backpressure();
        test_oob();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
